// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand feeder: FSM states, mode encodings
// and default widths.
package mac_pkg;

  // Job sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_READ  = 2'd3
  } feeder_state_t;

  // MAC arithmetic mode encodings
  localparam logic MODE_INT  = 1'b0;
  localparam logic MODE_FP16 = 1'b1;

  // Default configuration
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_LEN_W     = 8;
  localparam int DEF_DRAIN_CYC = 2;

endpackage

// File: rtl/mac_pair_fifo.sv
// Synchronous FIFO holding operand pairs. First-word fall-through read port:
// rdata always shows the oldest entry. Pointers carry one extra wrap bit so
// full and empty are distinguishable without an occupancy counter.
module mac_pair_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

  // A full FIFO refuses pushes even when a pop happens in the same cycle
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

  // Advance read and write pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Payload storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Operand feeder for the INT/FP16 MAC: queues operand pairs, streams a
// programmed number of them into the MAC one per cycle, waits for the MAC
// pipeline to drain, then strobes mac_read.
// Optional build macro: MAC_FEEDER_ZERO_SKIP_EN -- pairs with a zero operand
// are consumed and counted but issued with mac_valid low.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_a,
  input  logic [DATA_W-1:0] s_b,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic              mode_in,
  output logic              busy,
  output logic              done,
  output logic              mac_enable,
  output logic              mac_valid,
  output logic              mac_read,
  output logic              mac_mode,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b
);

  localparam int DCW = $clog2(DRAIN_CYC + 1);
  // Drain is entered on the final pop, so the first drain cycle overlaps the
  // last mac_valid; counting one extra cycle puts mac_read DRAIN_CYC+1
  // cycles after that valid.
  localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(DRAIN_CYC);
  localparam logic [DCW-1:0]   DC_ONE     = {{(DCW-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};

  feeder_state_t state_r, state_nxt;
  logic [LEN_W-1:0]  cnt_r, cnt_nxt, cnt_inc_s;
  logic [LEN_W-1:0]  len_r, len_nxt;
  logic [DCW-1:0]    drain_r, drain_nxt;
  logic              mode_r, mode_nxt;
  logic              zero_job_r, zero_job_nxt;

  logic              fifo_full_s, fifo_empty_s;
  logic [2*DATA_W-1:0] fifo_rdata_s;
  logic              push_s, pop_s, issue_s;
  logic [DATA_W-1:0] pop_a_s, pop_b_s;

  logic              busy_r, done_r, enable_r, valid_r, read_r;
  logic [DATA_W-1:0] a_r, b_r;

  assign s_ready    = !fifo_full_s;
  assign push_s     = s_valid && !fifo_full_s;
  assign pop_a_s    = fifo_rdata_s[2*DATA_W-1:DATA_W];
  assign pop_b_s    = fifo_rdata_s[DATA_W-1:0];
  assign cnt_inc_s  = cnt_r + LEN_ONE;

  assign busy       = busy_r;
  assign done       = done_r;
  assign mac_enable = enable_r;
  assign mac_valid  = valid_r;
  assign mac_read   = read_r;
  assign mac_mode   = mode_r;
  assign mac_a      = a_r;
  assign mac_b      = b_r;

  mac_pair_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata ({s_a, s_b}),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

`ifdef MAC_FEEDER_ZERO_SKIP_EN
  // FP16 ignores the sign bit so both +0 and -0 count as zero
  function automatic logic op_is_zero(input logic [DATA_W-1:0] op, input logic mode);
    logic z;
    if (mode == MODE_FP16) begin
      z = (op[DATA_W-2:0] == {(DATA_W-1){1'b0}});
    end else begin
      z = (op == {DATA_W{1'b0}});
    end
    return z;
  endfunction
`endif

  // Decide whether the pair popped this cycle is presented to the MAC
  always_comb begin
    issue_s = 1'b0;
`ifdef MAC_FEEDER_ZERO_SKIP_EN
    if (pop_s && (op_is_zero(pop_a_s, mode_r) || op_is_zero(pop_b_s, mode_r))) begin
      issue_s = 1'b0;
    end else begin
      issue_s = pop_s;
    end
`else
    issue_s = pop_s;
`endif
  end

  // Next-state, counter and pop control for the job sequencer
  always_comb begin
    state_nxt    = state_r;
    cnt_nxt      = cnt_r;
    len_nxt      = len_r;
    drain_nxt    = drain_r;
    mode_nxt     = mode_r;
    zero_job_nxt = zero_job_r;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          cnt_nxt   = {LEN_W{1'b0}};
          drain_nxt = {DCW{1'b0}};
          if (vec_len != {LEN_W{1'b0}}) begin
            len_nxt      = vec_len;
            mode_nxt     = mode_in;
            zero_job_nxt = 1'b0;
            state_nxt    = ST_RUN;
          end else begin
            zero_job_nxt = 1'b1;
            state_nxt    = ST_READ;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          cnt_nxt = cnt_inc_s;
          if (cnt_inc_s == len_r) begin
            drain_nxt = {DCW{1'b0}};
            state_nxt = ST_DRAIN;
          end else begin
            state_nxt = ST_RUN;
          end
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          state_nxt = ST_READ;
        end else begin
          drain_nxt = drain_r + DC_ONE;
        end
      end
      ST_READ: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and job bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {LEN_W{1'b0}};
      len_r      <= {LEN_W{1'b0}};
      drain_r    <= {DCW{1'b0}};
      mode_r     <= MODE_INT;
      zero_job_r <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      cnt_r      <= cnt_nxt;
      len_r      <= len_nxt;
      drain_r    <= drain_nxt;
      mode_r     <= mode_nxt;
      zero_job_r <= zero_job_nxt;
    end
  end

  // Registered MAC-side and status outputs, aligned with the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r   <= 1'b0;
      enable_r <= 1'b0;
      done_r   <= 1'b0;
      read_r   <= 1'b0;
      valid_r  <= 1'b0;
      a_r      <= {DATA_W{1'b0}};
      b_r      <= {DATA_W{1'b0}};
    end else begin
      busy_r   <= (state_nxt != ST_IDLE);
      enable_r <= busy_r;
      done_r   <= (state_nxt == ST_READ);
      read_r   <= (state_nxt == ST_READ) && !zero_job_nxt;
      valid_r  <= issue_s;
      if (pop_s) begin
        a_r <= pop_a_s;
        b_r <= pop_b_s;
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Self-checking bench for mac_operand_feeder. A queue models the FIFO; the
// expected MAC stream of a job is the first vec_len queued pairs, filtered
// by the zero-skip rule when that build option is enabled.
module tb_mac_operand_feeder;

  localparam int DATA_W    = 16;
  localparam int DEPTH     = 8;
  localparam int LEN_W     = 8;
  localparam int DRAIN_CYC = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_a, s_b;
  logic              start;
  logic [LEN_W-1:0]  vec_len;
  logic              mode_in;
  logic              busy, done, mac_enable, mac_valid, mac_read, mac_mode;
  logic [DATA_W-1:0] mac_a, mac_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] model_q[$];
  logic [31:0] obs_q[$];
  int first_valid_cyc, last_valid_cyc, read_cyc, done_cyc;
  int read_cnt, done_cnt, mode_err, start_cyc, job_len;
  bit job_mode;

  always #5 clk = ~clk;

  mac_operand_feeder #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .start(start), .vec_len(vec_len), .mode_in(mode_in),
    .busy(busy), .done(done), .mac_enable(mac_enable), .mac_valid(mac_valid),
    .mac_read(mac_read), .mac_mode(mac_mode), .mac_a(mac_a), .mac_b(mac_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pairs the MAC should not see as valid under the zero-skip option
  function automatic bit skip(input logic [31:0] p, input bit mode);
    bit r;
    r = 1'b0;
`ifdef MAC_FEEDER_ZERO_SKIP_EN
    if (mode) r = (p[30:16] == 15'd0) || (p[14:0] == 15'd0);
    else      r = (p[31:16] == 16'd0) || (p[15:0] == 16'd0);
`endif
    return r;
  endfunction

  // Advance one cycle and record MAC-side activity at the falling edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mac_valid === 1'b1) begin
      obs_q.push_back({mac_a, mac_b});
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      last_valid_cyc = cyc;
      if (mac_mode !== job_mode) mode_err++;
    end
    if (mac_read === 1'b1) begin read_cnt++; read_cyc = cyc; end
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
  endtask

  task automatic push_idle(input logic [15:0] a, input logic [15:0] b);
    s_valid = 1'b1; s_a = a; s_b = b;
    check("s_ready_idle", {63'd0, s_ready}, {63'd0, (model_q.size() < DEPTH)});
    if (model_q.size() < DEPTH) model_q.push_back({a, b});
    tick();
    s_valid = 1'b0;
  endtask

  task automatic push_busy(input logic [15:0] a, input logic [15:0] b);
    s_valid = 1'b1; s_a = a; s_b = b;
    check("s_ready_busy", {63'd0, s_ready}, 64'd1);
    model_q.push_back({a, b});
    tick();
    s_valid = 1'b0;
  endtask

  task automatic start_job(input int len, input bit mode);
    obs_q.delete();
    first_valid_cyc = -1; last_valid_cyc = -1; read_cyc = -1; done_cyc = -1;
    read_cnt = 0; done_cnt = 0; mode_err = 0;
    job_mode = mode; job_len = len;
    start = 1'b1; vec_len = LEN_W'(len); mode_in = mode;
    tick();
    start = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic finish_job(input int budget);
    logic [31:0] exp_q[$];
    logic [31:0] p;
    bit last_ok;
    int n;
    n = 0;
    last_ok = 1'b0;
    while (done_cnt == 0 && n < budget) begin tick(); n++; end
    check("done_within_budget", {63'd0, (done_cnt != 0)}, 64'd1);
    tick(); tick();
    check("done_pulses", 64'(done_cnt), 64'd1);
    for (int i = 0; i < job_len; i++) begin
      if (model_q.size() == 0) break;
      p = model_q.pop_front();
      last_ok = !skip(p, job_mode);
      if (last_ok) exp_q.push_back(p);
    end
    check("valid_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check("operands", {32'd0, obs_q[i]}, {32'd0, exp_q[i]});
    check("read_count", 64'(read_cnt), 64'((job_len != 0) ? 1 : 0));
    check("mode_during_valid", 64'(mode_err), 64'd0);
    if (job_len != 0 && last_ok) begin
      check("read_latency", 64'(read_cyc - last_valid_cyc), 64'(DRAIN_CYC + 1));
      check("done_with_read", 64'(done_cyc), 64'(read_cyc));
    end
    check("busy_after_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_reset_values();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_enable", {63'd0, mac_enable}, 64'd0);
    check("rst_valid", {63'd0, mac_valid}, 64'd0);
    check("rst_read", {63'd0, mac_read}, 64'd0);
    check("rst_mode", {63'd0, mac_mode}, 64'd0);
    check("rst_ab", {32'd0, mac_a, mac_b}, 64'd0);
    check("rst_s_ready", {63'd0, s_ready}, 64'd1);
  endtask

  initial begin
    int k, len;
    logic [15:0] ra, rb;
    rst_n = 1'b0; s_valid = 1'b0; s_a = 16'd0; s_b = 16'd0;
    start = 1'b0; vec_len = 8'd0; mode_in = 1'b0; job_mode = 1'b0;
    first_valid_cyc = -1; last_valid_cyc = -1;

    // Reset state
    tick();
    check_reset_values();
    rst_n = 1'b1;
    tick();

    // Basic FP16 job with the reference operands
    push_idle(16'h414C, 16'h9762);
    push_idle(16'h3C00, 16'h4000);
    push_idle(16'h0001, 16'h0002);
    start_job(3, 1'b1);
    check("enable_lags_busy", {63'd0, mac_enable}, 64'd0);
    tick();
    check("enable_follows_busy", {63'd0, mac_enable}, 64'd1);
    check("first_valid_latency", 64'(first_valid_cyc), 64'(start_cyc + 1));
    finish_job(100);
    check("valid_back_to_back", 64'(last_valid_cyc - first_valid_cyc), 64'd2);

    // Backpressure: fill, refuse a ninth pair, then drain with a full job
    for (int i = 0; i < 9; i++) push_idle(16'(100 + i), 16'(200 + i));
    check("full_not_ready", {63'd0, s_ready}, 64'd0);
    start_job(8, 1'b0);
    check("still_full_before_pop", {63'd0, s_ready}, 64'd0);
    tick();
    check("ready_after_pop", {63'd0, s_ready}, 64'd1);
    finish_job(100);

    // Underflow stall, then completion once more pairs arrive
    push_idle(16'h1111, 16'h2222);
    push_idle(16'h3333, 16'h4444);
    start_job(4, 1'b0);
    repeat (6) tick();
    check("stall_valid_count", 64'(obs_q.size()), 64'd2);
    check("stall_busy", {63'd0, busy}, 64'd1);
    check("stall_no_done", 64'(done_cnt), 64'd0);
    push_busy(16'h5555, 16'h6666);
    push_busy(16'h7777, 16'h8888);
    finish_job(100);

    // Zero-length job
    start_job(0, 1'b0);
    finish_job(20);

    // Start while running is ignored; excess pairs stay queued
    for (int i = 0; i < 5; i++) push_idle(16'($urandom), 16'($urandom));
    start_job(3, 1'b1);
    start = 1'b1; vec_len = 8'd1; mode_in = 1'b0;
    tick();
    start = 1'b0;
    finish_job(100);
    repeat (2) tick();
    check("ignored_start_idle", {63'd0, busy}, 64'd0);
    check("leftover_pairs", 64'(model_q.size()), 64'd2);
    start_job(2, 1'b0);
    finish_job(100);

    // Zero operands (skipped only when the option is built in)
    push_idle(16'h8000, 16'h3C00);
    push_idle(16'h1234, 16'h5678);
    start_job(2, 1'b1);
    finish_job(100);
    push_idle(16'h8000, 16'h0001);
    push_idle(16'h0000, 16'h0005);
    push_idle(16'h0102, 16'h0304);
    start_job(3, 1'b0);
    finish_job(100);

    // Randomized jobs against the queue model
    for (int j = 0; j < 6; j++) begin
      k = $urandom_range(1, DEPTH - model_q.size());
      for (int i = 0; i < k; i++) begin
        ra = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        rb = 16'($urandom);
        push_idle(ra, rb);
      end
      len = $urandom_range(1, model_q.size());
      start_job(len, 1'($urandom_range(0, 1)));
      finish_job(100);
    end

    // Reset during DRAIN: no done, FIFO emptied
    while (model_q.size() < 4) push_idle(16'($urandom), 16'($urandom));
    start_job(2, 1'b0);
    k = 0;
    while (obs_q.size() < 2 && k < 20) begin tick(); k++; end
    check("reach_drain", 64'(obs_q.size()), 64'd2);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_values();
    model_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("no_done_after_abort", 64'(done_cnt), 64'd0);
    push_idle(16'hABCD, 16'h1357);
    start_job(1, 1'b1);
    finish_job(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_operand_feeder.md
# mac_operand_feeder

Upstream operand stage for the 16-bit INT/FP16 multiply-accumulate unit. Buffers incoming operand pairs in a small FIFO and streams them one pair per cycle into the MAC's `in_a`/`in_b`/`valid` inputs for a programmed vector length. When the vector completes, it waits for the MAC pipeline to settle, then pulses the MAC's `read` to deliver the accumulated dot product.

## Interface
- `DATA_W`, 16, operand width; must match the MAC operand width.
- `DEPTH`, 8, FIFO depth in operand pairs; must be a power of two, ≥2.
- `LEN_W`, 8, width of the vector-length field.
- `DRAIN_CYC`, 2, idle cycles between the last issued pair and `mac_read`; must be ≥1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: upstream operand pair valid.
- `s_ready` out 1: FIFO can accept a pair.
- `s_a` in DATA_W: operand A.
- `s_b` in DATA_W: operand B.
- `start` in 1: single-cycle job start request.
- `vec_len` in LEN_W: number of pairs in the job; sampled when `start` is accepted.
- `mode_in` in 1: 0 = INT, 1 = FP16; sampled when `start` is accepted.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle pulse marking job completion.
- `mac_enable` out 1: MAC enable.
- `mac_valid` out 1: MAC operand valid.
- `mac_read` out 1: MAC result read strobe.
- `mac_mode` out 1: MAC arithmetic mode.
- `mac_a` out DATA_W: MAC operand A.
- `mac_b` out DATA_W: MAC operand B.

## Operation
- **FIFO**
  - Push when `s_valid && s_ready`. `s_ready = !full`, so a full FIFO refuses a push even if a pop occurs in the same cycle.
  - Pointers are log2(DEPTH) bits plus a wrap bit.
  - FIFO contents persist across jobs. Pairs in excess of `vec_len` stay queued for the next job.
- **FSM states**
  - IDLE
    - `start` with `vec_len != 0`: latch `vec_len` and `mode_in`, clear the issue counter, go to RUN.
    - `start` with `vec_len == 0`: go to READ without issuing any pairs and without asserting `mac_read` (`done` only).
  - RUN
    - Each cycle the FIFO is non-empty: pop one pair, register it onto `mac_a`/`mac_b`, set `mac_valid = 1` next cycle, and increment the counter.
    - FIFO empty: stall; `mac_valid = 0` and `mac_a`/`mac_b` hold.
    - When the counter reaches the latched length on a pop: go to DRAIN.
  - DRAIN: count `DRAIN_CYC` cycles with `mac_valid = 0`, then go to READ.
  - READ: one cycle with `mac_read = 1` and `done = 1`, then go to IDLE.
- **Outputs**
  - `start` is ignored when not in IDLE.
  - `busy = 1` whenever the FSM is not in IDLE.
  - `mac_enable` is a registered copy of `busy`.
  - `mac_mode` holds the latched mode for the whole job.
- **Reset:** asserting `rst_n` low mid-job aborts immediately. FIFO and all state are cleared and no `done` pulse is produced.

## Timing
- Reset values: `busy`, `done`, `mac_enable`, `mac_valid`, `mac_read`, `mac_mode` = 0; `mac_a` = `mac_b` = 0. `s_ready` = 1, since the FIFO is empty.
- `start` accepted at edge N: `busy` = 1 from N+1. The first pop is possible in the cycle after N+1; its `mac_valid` appears one cycle after that pop.
- Latency is one cycle from FIFO pop to `mac_valid`.
- Sustained throughput is one pair per cycle while the FIFO is non-empty.
- `mac_read` asserts exactly `DRAIN_CYC` + 1 cycles after the last `mac_valid` cycle.
- A push and a pop in the same cycle when not full leave the occupancy unchanged.

## Configuration
- `MAC_FEEDER_ZERO_SKIP_EN` defined: a popped pair is counted but issued with `mac_valid = 0` if either operand is zero.
  - INT mode zero test: all bits clear.
  - FP16 mode zero test: `[14:0]` clear, which covers both ±0.
- `MAC_FEEDER_ZERO_SKIP_EN` undefined: every popped pair issues with `mac_valid = 1`.

## Structure
- Shared package `mac_pkg`:
  - FSM state enum (IDLE/RUN/DRAIN/READ).
  - Mode constants `MODE_INT` = 0 and `MODE_FP16` = 1.
  - Default width constants.
- One sub-module, `mac_pair_fifo`: a synchronous FIFO with a (DATA_W×2)-bit payload and full/empty flags.
- The FSM, issue counter, and output registers are in the top level.

## Test plan
- **Reset:** assert `rst_n` = 0 → all outputs at their reset values and `s_ready` = 1.
- **Basic job:** push pairs (0x414C, 0x9762), (0x3C00, 0x4000), (0x0001, 0x0002); `start` with `vec_len` = 3, `mode_in` = 1 → three consecutive `mac_valid` cycles with those operands and `mac_mode` = 1. `mac_read` and `done` assert 3 cycles after the last valid.
- **Backpressure:** push 8 pairs with no job running → `s_ready` = 0 and a 9th `s_valid` is not accepted. Then start a job with `vec_len` = 8 → `s_ready` returns to 1 after the first pop.
- **Underflow stall:** `start` with `vec_len` = 4 and only 2 pairs queued → 2 valid cycles, then stall with `busy` = 1. Pushing 2 more pairs completes the job.
- **Zero length and busy-start:** `start` with `vec_len` = 0 → `done` pulses, no `mac_valid`, no `mac_read`. A second `start` during RUN is ignored.
- **Mid-job reset and zero-skip:**
  - Drop `rst_n` during DRAIN → no `done` and the FIFO is emptied.
  - With `MAC_FEEDER_ZERO_SKIP_EN`, a pair (0x8000, 0x3C00) in FP16 mode → counted with `mac_valid` = 0.
